// File: rtl/mat_pkg.sv
// Shared definitions for the matrix text formatter: ASCII codes, FSM states,
// default FIFO depth and the binary-to-BCD helper.
package mat_pkg;

  localparam int DEF_FIFO_DEPTH = 64;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIGIT,
    SEP,
    LF
  } fmt_state_e;

  // Double-dabble: {hundreds, tens, units}, exact for 0..255.
  function automatic logic [11:0] bin2bcd(input logic [7:0] bin);
    logic [19:0] sr;
    sr = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sr[11:8]  >= 4'd5) sr[11:8]  = sr[11:8]  + 4'd3;
      if (sr[15:12] >= 4'd5) sr[15:12] = sr[15:12] + 4'd3;
      if (sr[19:16] >= 4'd5) sr[19:16] = sr[19:16] + 4'd3;
      sr = sr << 1;
    end
    return sr[19:8];
  endfunction

endpackage

// File: rtl/mat_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data. The caller
// guarantees no pop when empty and no push when full unless popping.
module mat_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // NOTE: storage is deliberately not reset; only pointers and count are,
  // which keeps the array a plain RAM and makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/mat_uart_formatter.sv
// Renders the element stream as ASCII decimal rows (space separated, CR LF
// per row) onto a valid/ready byte port. Define MAT_FMT_PAD_EN for fixed
// 3-character right-aligned fields instead of leading-zero suppression.
module mat_uart_formatter
  import mat_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_elem,
  input  logic                  in_row_end,
  input  logic                  in_last,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic                  last;
    logic                  row_end;
    logic [DATA_WIDTH-1:0] elem;
  } entry_t;

  entry_t     fifo_wr;
  entry_t     fifo_rd;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [AW:0] fifo_count;

  fmt_state_e state;
  fmt_state_e state_next;
  entry_t     elem_q;
  logic [11:0] digits_q;
  logic [1:0]  idx_q;
  logic [11:0] bcd;
  logic [1:0]  first_idx;
  logic [3:0]  cur_digit;
  logic [7:0]  digit_char;
  logic        tx_accept;
`ifdef MAT_FMT_PAD_EN
  logic [1:0]  lead_q;
`endif

  // A pop frees a slot in the same cycle, so a push while full is still legal.
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign fifo_push = in_valid && (!fifo_full || fifo_pop);
  assign fifo_wr   = '{last: in_last, row_end: in_row_end, elem: in_elem};
  assign tx_accept = tx_valid && tx_ready;

  mat_sync_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (fifo_wr),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    bcd = bin2bcd(8'(elem_q.elem));
    if (bcd[11:8] != 4'd0)     first_idx = 2'd0;
    else if (bcd[7:4] != 4'd0) first_idx = 2'd1;
    else                       first_idx = 2'd2;
  end

  always_comb begin
    case (idx_q)
      2'd0:    cur_digit = digits_q[11:8];
      2'd1:    cur_digit = digits_q[7:4];
      default: cur_digit = digits_q[3:0];
    endcase
    digit_char = ASCII_0 + {4'd0, cur_digit};
`ifdef MAT_FMT_PAD_EN
    if (idx_q < lead_q) digit_char = ASCII_SP;
`endif
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    case (state)
      IDLE:  if (!fifo_empty) state_next = LOAD;
      LOAD:  state_next = DIGIT;
      DIGIT: begin
        tx_valid = 1'b1;
        tx_data  = digit_char;
        if (tx_ready && idx_q == 2'd2) state_next = SEP;
      end
      SEP: begin
        tx_valid = 1'b1;
        tx_data  = elem_q.row_end ? ASCII_CR : ASCII_SP;
        if (tx_ready) state_next = elem_q.row_end ? LF : IDLE;
      end
      LF: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_LF;
        if (tx_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      elem_q     <= '0;
      digits_q   <= '0;
      idx_q      <= '0;
`ifdef MAT_FMT_PAD_EN
      lead_q     <= '0;
`endif
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_next;
      if (fifo_pop) elem_q <= fifo_rd;
      if (state == LOAD) begin
        digits_q <= bcd;
`ifdef MAT_FMT_PAD_EN
        idx_q    <= 2'd0;
        lead_q   <= first_idx;
`else
        idx_q    <= first_idx;
`endif
      end else if (state == DIGIT && tx_accept) begin
        idx_q <= idx_q + 2'd1;
      end
      // The final byte of a frame is the space, or the LF when the row ends.
      frame_done <= tx_accept && elem_q.last &&
                    ((state == SEP && !elem_q.row_end) || state == LF);
      overflow   <= overflow | (in_valid && fifo_full && !fifo_pop);
      busy       <= fifo_push || (state != IDLE) || (fifo_count != '0);
    end
  end

endmodule
